// File: rtl/encoder.sv
// Registered 4-input priority encoder with valid and multi-hot flags.
// The arbitration order and the idle behaviour are selected by parameters.
module encoder #(
    parameter bit PRIORITY_HIGH = 1'b1,
    parameter bit HOLD_LAST     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_1,
    input  logic       input_2,
    input  logic       input_3,
    input  logic       input_4,
    output logic [1:0] encoded_output,
    output logic       valid,
    output logic       multi_hot
);

    logic [3:0] req;
    logic [1:0] hi_code;
    logic [1:0] lo_code;
    logic [1:0] win_code;
    logic       any_req;
    logic       multi_req;

    logic [1:0] code_q;
    logic [1:0] code_d;
    logic       valid_q;
    logic       valid_d;
    logic       multi_q;
    logic       multi_d;

    assign req = {input_4, input_3, input_2, input_1};

    always_comb begin
        hi_code = 2'b00;
        if (req[3]) begin
            hi_code = 2'b11;
        end else if (req[2]) begin
            hi_code = 2'b10;
        end else if (req[1]) begin
            hi_code = 2'b01;
        end
    end

    always_comb begin
        lo_code = 2'b00;
        if (req[0]) begin
            lo_code = 2'b00;
        end else if (req[1]) begin
            lo_code = 2'b01;
        end else if (req[2]) begin
            lo_code = 2'b10;
        end else if (req[3]) begin
            lo_code = 2'b11;
        end
    end

    assign win_code = PRIORITY_HIGH ? hi_code : lo_code;
    assign any_req  = |req;

    // Two or more set bits is exactly "some pair of bits is set".
    assign multi_req = (req[0] & req[1]) | (req[0] & req[2]) |
                       (req[0] & req[3]) | (req[1] & req[2]) |
                       (req[1] & req[3]) | (req[2] & req[3]);

    always_comb begin
        valid_d = any_req;
        multi_d = multi_req;
        code_d  = 2'b00;
        if (any_req) begin
            code_d = win_code;
        end else if (HOLD_LAST) begin
            code_d = code_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign encoded_output = code_q;
    assign valid          = valid_q;
    assign multi_hot      = multi_q;

endmodule

// File: tb/tb_encoder.sv
// Bench for encoder: four parameter variants share one stimulus stream
// and are compared against a per-variant behavioural model.
module tb_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in1 = 1'b0, in2 = 1'b0, in3 = 1'b0, in4 = 1'b0;

    logic [1:0] code [4];
    logic       vld  [4];
    logic       mh   [4];

    // variant i: PRIORITY_HIGH = ph[i], HOLD_LAST = hl[i]
    bit ph [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit hl [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    logic [1:0] m_code [4];
    logic       m_vld;
    logic       m_mh;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder #(.PRIORITY_HIGH(1'b1), .HOLD_LAST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .input_1(in1), .input_2(in2), .input_3(in3), .input_4(in4),
        .encoded_output(code[0]), .valid(vld[0]), .multi_hot(mh[0]));
    encoder #(.PRIORITY_HIGH(1'b0), .HOLD_LAST(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .input_1(in1), .input_2(in2), .input_3(in3), .input_4(in4),
        .encoded_output(code[1]), .valid(vld[1]), .multi_hot(mh[1]));
    encoder #(.PRIORITY_HIGH(1'b1), .HOLD_LAST(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n),
        .input_1(in1), .input_2(in2), .input_3(in3), .input_4(in4),
        .encoded_output(code[2]), .valid(vld[2]), .multi_hot(mh[2]));
    encoder #(.PRIORITY_HIGH(1'b0), .HOLD_LAST(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n),
        .input_1(in1), .input_2(in2), .input_3(in3), .input_4(in4),
        .encoded_output(code[3]), .valid(vld[3]), .multi_hot(mh[3]));

    function automatic logic [1:0] winner(bit high, logic [3:0] r);
        if (high) begin
            for (int k = 3; k >= 0; k--) if (r[k]) return 2'(k);
        end else begin
            for (int k = 0; k < 4; k++) if (r[k]) return 2'(k);
        end
        return 2'b00;
    endfunction

    // r[k-1] drives input_k; the model advances on the sampling edge.
    task automatic drive(input logic [3:0] r);
        @(negedge clk);
        {in4, in3, in2, in1} = r;
        @(posedge clk);
        m_vld = |r;
        m_mh  = $countones(r) >= 2;
        for (int i = 0; i < 4; i++) begin
            if (|r) m_code[i] = winner(ph[i], r);
            else if (!hl[i]) m_code[i] = 2'b00;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (code[i] !== 2'b00 || vld[i] !== 1'b0 || mh[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d got %b/%b/%b want 00/0/0",
                         i, code[i], vld[i], mh[i]);
            end
            m_code[i] = 2'b00;
        end
        m_vld = 1'b0;
        m_mh  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        drive(4'b0101);
        checks++;
        if (code[0] !== 2'b10 || vld[0] !== 1'b1 || mh[0] !== 1'b1) begin
            errors++;
            $display("FAIL vec1010 got %b/%b/%b want 10/1/1",
                     code[0], vld[0], mh[0]);
        end
        checks++;
        if (code[1] !== 2'b00 || mh[1] !== 1'b1) begin
            errors++;
            $display("FAIL vec1010_lo got %b/%b want 00/1", code[1], mh[1]);
        end
        drive(4'b1010);
        checks++;
        if (code[0] !== 2'b11 || vld[0] !== 1'b1 || mh[0] !== 1'b1) begin
            errors++;
            $display("FAIL vec0101 got %b/%b/%b want 11/1/1",
                     code[0], vld[0], mh[0]);
        end
        checks++;
        if (code[1] !== 2'b01 || mh[1] !== 1'b1) begin
            errors++;
            $display("FAIL vec0101_lo got %b/%b want 01/1", code[1], mh[1]);
        end
        drive(4'b0100);
        checks++;
        if (code[0] !== 2'b10 || vld[0] !== 1'b1 || mh[0] !== 1'b0) begin
            errors++;
            $display("FAIL single got %b/%b/%b want 10/1/0",
                     code[0], vld[0], mh[0]);
        end
        drive(4'b0000);
        checks++;
        if (code[0] !== 2'b10 || vld[0] !== 1'b0 || mh[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold got %b/%b/%b want 10/0/0",
                     code[0], vld[0], mh[0]);
        end
        checks++;
        if (code[2] !== 2'b00 || vld[2] !== 1'b0) begin
            errors++;
            $display("FAIL nohold got %b/%b want 00/0", code[2], vld[2]);
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (code[i] !== 2'b00 || vld[i] !== 1'b0 || mh[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_rst dut%0d got %b/%b/%b want 00/0/0",
                         i, code[i], vld[i], mh[i]);
            end
            m_code[i] = 2'b00;
        end
        #1;
        rst_n = 1'b1;
        drive(4'b1111);
        checks++;
        if (code[0] !== 2'b11 || vld[0] !== 1'b1 || mh[0] !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got %b/%b/%b want 11/1/1",
                     code[0], vld[0], mh[0]);
        end
        checks++;
        if (code[1] !== 2'b00 || mh[1] !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_lo got %b/%b want 00/1", code[1], mh[1]);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            for (int z = 0; z < 2; z++) begin
                drive(z == 0 ? 4'(v) : 4'b0000);
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (code[i] !== m_code[i] || vld[i] !== m_vld ||
                        mh[i] !== m_mh) begin
                        errors++;
                        $display("FAIL sweep v=%0d z=%0d dut%0d got %b/%b/%b want %b/%b/%b",
                                 v, z, i, code[i], vld[i], mh[i],
                                 m_code[i], m_vld, m_mh);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            drive(4'($urandom_range(0, 15)));
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (code[i] !== m_code[i] || vld[i] !== m_vld ||
                    mh[i] !== m_mh) begin
                    errors++;
                    $display("FAIL random n=%0d dut%0d got %b/%b/%b want %b/%b/%b",
                             n, i, code[i], vld[i], mh[i],
                             m_code[i], m_vld, m_mh);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder.md
ENCODER -- requirements
Module: encoder

Interface
REQ-001 The block SHALL have exactly one clock and one reset, with the reset asynchronous and active-low.
REQ-002 Parameter PRIORITY_HIGH, default 1, SHALL select the arbitration rule: 1 = input_4 has the highest priority; 0 = input_1 has the highest priority.
REQ-003 Parameter HOLD_LAST, default 1, SHALL select the idle behaviour: 1 = hold the last code when no input is active; 0 = drive 2'b00 when no input is active.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports input_1, input_2, input_3, input_4, input, 1 bit each: request lines; all four SHALL be synchronous to clk.
REQ-007 Port encoded_output, output, 2 bits: registered code of the winning request.
REQ-008 Port valid, output, 1 bit: registered; 1 when at least one input was active at the sampling edge.
REQ-009 Port multi_hot, output, 1 bit: registered; 1 when two or more inputs were active at the sampling edge.

Function
REQ-010 Input input_k SHALL map to code k-1: input_1 -> 00, input_2 -> 01, input_3 -> 10, input_4 -> 11.
REQ-011 When PRIORITY_HIGH=1, the active input with the highest index SHALL win.
REQ-012 When PRIORITY_HIGH=0, the active input with the lowest index SHALL win.
REQ-013 All inputs SHALL be sampled on each rising clk edge.
REQ-014 All outputs SHALL be registered and reflect the inputs sampled at that edge, giving a latency of exactly 1 cycle.
REQ-015 The inputs SHALL have no combinational path to any output.
REQ-016 The block SHALL have no enable, so every edge updates the outputs.
REQ-017 valid SHALL equal the OR of the four sampled inputs.
REQ-018 multi_hot SHALL be 1 when the population count of the sampled inputs is 2 or more, and 0 otherwise.
REQ-019 When no input is active and HOLD_LAST=1, encoded_output SHALL keep its previous value and valid SHALL be 0.
REQ-020 When no input is active and HOLD_LAST=0, encoded_output SHALL be 00 and valid SHALL be 0.
REQ-021 When all four inputs are active, the winner SHALL be input_4 (11) with PRIORITY_HIGH=1, or input_1 (00) with PRIORITY_HIGH=0; multi_hot SHALL be 1.
REQ-022 The block SHALL be stateless apart from the output registers, so consecutive cycles are independent except for the HOLD_LAST hold value.

Reset
REQ-023 While rst_n=0, encoded_output SHALL be 00, valid SHALL be 0 and multi_hot SHALL be 0, regardless of clk.
REQ-024 Assertion of rst_n SHALL take effect immediately, including mid-operation.
REQ-025 After rst_n deasserts, the first rising edge SHALL capture the inputs normally.
REQ-026 The hold value after reset SHALL be 00.

Verification
REQ-027 Defaults, inputs (1,2,3,4)=(1,0,1,0), one edge -> encoded_output=10, valid=1, multi_hot=1.
REQ-028 Defaults, inputs (0,1,0,1), one edge -> encoded_output=11, valid=1, multi_hot=1.
REQ-029 PRIORITY_HIGH=0, inputs (1,0,1,0) then (0,1,0,1) -> encoded_output=00, then 01, with multi_hot=1 on both.
REQ-030 Defaults, (0,0,1,0) then (0,0,0,0) -> first 10/valid=1/multi_hot=0, then 10 held with valid=0; with HOLD_LAST=0 the second response SHALL be 00/valid=0.
REQ-031 Drive (1,1,1,1) and pulse rst_n low between edges -> outputs go to 00/0/0 asynchronously, and the first edge after release gives 11/1/1.
REQ-032 Sweep all 16 input combinations under both PRIORITY_HIGH values -> every output SHALL match a reference model with 1-cycle latency.
